// File: rtl/wb_ram_rmw.sv
// wb_ram_rmw - Wishbone classic slave RAM with byte-lane read-modify-write.
//
// Single-port synchronous RAM behind a Wishbone classic slave. Writes with all
// byte lanes enabled complete in one cycle. Writes with any other non-zero lane
// pattern read the old word first, merge the selected lanes, then write the
// merged word back. Accesses with no lanes selected, or with address bits above
// the array set, terminate on wb_err_o and never touch the array. An optional
// sweep writes zero into every word after reset before the bus is served.
//
// Ports
//   wb_clk_i     clock, all state on the rising edge
//   wb_rst_i     asynchronous active-high reset
//   wb_addr_i    byte address; word index = addr[LSB+IDX_W-1:LSB]
//   wb_data_i    write data, lane k = bits 8k+7:8k
//   wb_sel_i     byte-lane enables, any pattern
//   wb_we_i      1 = write
//   wb_cyc_i     bus cycle
//   wb_stb_i     strobe
//   wb_ack_o     normal termination, one-cycle pulse
//   wb_err_o     error termination, one-cycle pulse
//   wb_data_o    registered read data, unselected lanes zero
//   init_done_o  high once the clear sweep is finished (or straight after
//                reset when no sweep is configured)
//
// State | meaning
// ------+------------------------------------------------------------------
// INIT  | clear sweep: zero written to word cnt each cycle
// IDLE  | waiting for cyc & stb; full writes and errors finish here
// RD    | RAM read in flight; reads respond, partial writes go to WR
// WR    | merge selected lanes into old word and write it back
// ACK   | ack/err visible for this one cycle, then back to IDLE unsampled

module wb_ram_rmw #(
    parameter int    WB_DATA_WIDTH   = 32,
    parameter int    WB_ADDR_WIDTH   = 32,
    parameter int    WB_RAM_WORDS    = 1024,
    parameter string WB_RAM_MEM_FILE = "",
    parameter bit    CLEAR_ON_RESET  = 1'b0
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [WB_DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     init_done_o
);

    localparam int SEL_W  = WB_DATA_WIDTH / 8;
    localparam int LSB    = $clog2(SEL_W);
    localparam int IDX_W  = $clog2(WB_RAM_WORDS);
    localparam int HI_LSB = LSB + IDX_W;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_ACK
    } state_t;

    state_t                   state_q, state_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [WB_DATA_WIDTH-1:0] data_q, data_d;
    logic                     init_done_q, init_done_d;
    logic [IDX_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic                     we_q, we_d;

    // RAM port
    logic [WB_DATA_WIDTH-1:0] mem [WB_RAM_WORDS];
    logic                     ram_we_raw;
    logic                     ram_we;
    logic                     ram_re;
    logic [IDX_W-1:0]         ram_idx;
    logic [WB_DATA_WIDTH-1:0] ram_wdata;
    logic [WB_DATA_WIDTH-1:0] ram_rdata_q;

    logic                     req;
    logic [IDX_W-1:0]         addr_idx;
    logic                     addr_hi_bad;
    logic                     illegal;
    logic                     sel_full;
    logic [WB_DATA_WIDTH-1:0] sel_mask_q;
    logic                     unused_addr_lsb;

    function automatic logic [WB_DATA_WIDTH-1:0] lane_mask(input logic [SEL_W-1:0] sel);
        logic [WB_DATA_WIDTH-1:0] m;
        m = '0;
        for (int k = 0; k < SEL_W; k++) begin
            m[8*k +: 8] = {8{sel[k]}};
        end
        return m;
    endfunction

    // Lanes are absolute: the byte offset inside a word carries no meaning.
    assign unused_addr_lsb = ^wb_addr_i[LSB-1:0];

    assign req         = wb_cyc_i & wb_stb_i;
    assign addr_idx    = wb_addr_i[HI_LSB-1:LSB];
    assign addr_hi_bad = (wb_addr_i >> HI_LSB) != '0;
    assign illegal     = (wb_sel_i == '0) | addr_hi_bad;
    assign sel_full    = &wb_sel_i;
    assign sel_mask_q  = lane_mask(sel_q);

    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        data_d      = data_q;
        init_done_d = init_done_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sel_d       = sel_q;
        we_d        = we_q;
        ram_we_raw  = 1'b0;
        ram_re      = 1'b0;
        ram_idx     = idx_q;
        ram_wdata   = '0;

        case (state_q)
            ST_INIT: begin
                ram_idx    = cnt_q;
                ram_wdata  = '0;
                ram_we_raw = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(WB_RAM_WORDS - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end

            ST_IDLE: begin
                ram_idx = addr_idx;
                if (req) begin
                    if (illegal) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = ST_ACK;
                    end else if (wb_we_i && sel_full) begin
                        ram_wdata  = wb_data_i;
                        ram_we_raw = 1'b1;
                        ack_d      = 1'b1;
                        state_d    = ST_ACK;
                    end else begin
                        // Reads and partial writes both need the old word first.
                        ram_re  = 1'b1;
                        idx_d   = addr_idx;
                        sel_d   = wb_sel_i;
                        we_d    = wb_we_i;
                        state_d = ST_RD;
                    end
                end
            end

            ST_RD: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (!we_q) begin
                    data_d  = ram_rdata_q & sel_mask_q;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_WR;
                end
            end

            ST_WR: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    ram_wdata  = (wb_data_i & sel_mask_q) | (ram_rdata_q & ~sel_mask_q);
                    ram_we_raw = 1'b1;
                    ack_d      = 1'b1;
                    state_d    = ST_ACK;
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset gates the write strobe combinationally so an edge that coincides
    // with reset can never land a partial or merged word.
    assign ram_we = ram_we_raw & ~wb_rst_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= '0;
            init_done_q <= ~CLEAR_ON_RESET;
            cnt_q       <= '0;
            idx_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
        end
    end

    // Plain synchronous RAM, no reset so it maps onto block memory. The read
    // register holds its value until the next read, which WR relies on.
    always_ff @(posedge wb_clk_i) begin
        if (ram_we) begin
            mem[ram_idx] <= ram_wdata;
        end
        if (ram_re) begin
            ram_rdata_q <= mem[ram_idx];
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign wb_data_o   = data_q;
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_wb_ram_rmw.sv
module tb_wb_ram_rmw;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance: 16 words, clear sweep after reset
    logic        rst32;
    logic [31:0] addr32;
    logic [31:0] wdat32;
    logic [3:0]  sel32;
    logic        we32, cyc32, stb32;
    logic        ack32, err32, init32;
    logic [31:0] rdat32;

    // 64-bit instance: 16 words, no sweep
    logic        rst64;
    logic [31:0] addr64;
    logic [63:0] wdat64;
    logic [7:0]  sel64;
    logic        we64, cyc64, stb64;
    logic        ack64, err64, init64;
    logic [63:0] rdat64;

    wb_ram_rmw #(
        .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .WB_RAM_WORDS(16),
        .WB_RAM_MEM_FILE(""), .CLEAR_ON_RESET(1'b1)
    ) dut32 (
        .wb_clk_i(clk), .wb_rst_i(rst32), .wb_addr_i(addr32), .wb_data_i(wdat32),
        .wb_sel_i(sel32), .wb_we_i(we32), .wb_cyc_i(cyc32), .wb_stb_i(stb32),
        .wb_ack_o(ack32), .wb_err_o(err32), .wb_data_o(rdat32), .init_done_o(init32)
    );

    wb_ram_rmw #(
        .WB_DATA_WIDTH(64), .WB_ADDR_WIDTH(32), .WB_RAM_WORDS(16),
        .WB_RAM_MEM_FILE(""), .CLEAR_ON_RESET(1'b0)
    ) dut64 (
        .wb_clk_i(clk), .wb_rst_i(rst64), .wb_addr_i(addr64), .wb_data_i(wdat64),
        .wb_sel_i(sel64), .wb_we_i(we64), .wb_cyc_i(cyc64), .wb_stb_i(stb64),
        .wb_ack_o(ack64), .wb_err_o(err64), .wb_data_o(rdat64), .init_done_o(init64)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit d64, input bit req, input bit we, input logic [31:0] addr,
                         input logic [63:0] data, input logic [7:0] sel);
        if (d64) begin
            cyc64 = req; stb64 = req; we64 = we; addr64 = addr; wdat64 = data; sel64 = sel;
        end else begin
            cyc32 = req; stb32 = req; we32 = we; addr32 = addr; wdat32 = data[31:0]; sel32 = sel[3:0];
        end
    endtask

    // One bus transaction; lat = edges from request sample until ack/err is seen.
    task automatic xact(input bit d64, input bit we, input logic [31:0] addr,
                        input logic [63:0] data, input logic [7:0] sel,
                        output int lat, output logic ack, output logic err, output logic [63:0] rd);
        @(negedge clk);
        drive(d64, 1'b1, we, addr, data, sel);
        lat = 0;
        ack = 1'b0;
        err = 1'b0;
        while (!(ack || err) && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            ack = d64 ? ack64 : ack32;
            err = d64 ? err64 : err32;
        end
        rd = d64 ? rdat64 : {32'h0, rdat32};
        if (!(ack || err)) check("xact_timeout", 64'(lat), 64'd0);
        @(negedge clk);
        drive(d64, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    endtask

    int          lat;
    logic        ack, err;
    logic [63:0] rd;
    int          n;
    int          done_at;
    logic        seen;

    initial begin
        rst32 = 1'b1;
        rst64 = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
        #1;
        check("rst_ack32", ack32, 1'b0);
        check("rst_err32", err32, 1'b0);
        check("rst_data32", rdat32, 32'h0);
        check("rst_init32", init32, 1'b0);
        check("rst_init64", init64, 1'b1);
        check("rst_data64", rdat64, 64'h0);

        @(negedge clk);
        rst32 = 1'b0;
        rst64 = 1'b0;
        n = 0;
        while (!init32 && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("init_edges", 64'(n), 64'd16);

        // full write then read
        xact(1'b0, 1'b1, 32'h10, 64'hDEADBEEF, 8'hF, lat, ack, err, rd);
        check("wr_full_lat", 64'(lat), 64'd1);
        check("wr_full_ack", ack, 1'b1);
        check("wr_full_err", err, 1'b0);
        xact(1'b0, 1'b0, 32'h10, 64'h0, 8'hF, lat, ack, err, rd);
        check("rd_lat", 64'(lat), 64'd2);
        check("rd_data", rd, 64'hDEADBEEF);

        // read-modify-write
        xact(1'b0, 1'b1, 32'h14, 64'h11223344, 8'hF, lat, ack, err, rd);
        xact(1'b0, 1'b1, 32'h14, 64'hAABBCCDD, 8'hA, lat, ack, err, rd);
        check("rmw_lat", 64'(lat), 64'd3);
        check("rmw_ack", ack, 1'b1);
        xact(1'b0, 1'b0, 32'h14, 64'h0, 8'hF, lat, ack, err, rd);
        check("rmw_data", rd, 64'hAA22CC44);
        xact(1'b0, 1'b0, 32'h17, 64'h0, 8'h3, lat, ack, err, rd);
        check("rd_partial_sel", rd, 64'h0000CC44);

        // error terminations
        xact(1'b0, 1'b0, 32'h10, 64'h0, 8'h0, lat, ack, err, rd);
        check("err_sel0_err", err, 1'b1);
        check("err_sel0_ack", ack, 1'b0);
        check("err_sel0_lat", 64'(lat), 64'd1);
        check("err_sel0_data", rd, 64'h0);
        xact(1'b0, 1'b1, 32'h0, 64'h13579BDF, 8'hF, lat, ack, err, rd);
        xact(1'b0, 1'b1, 32'h40, 64'h55555555, 8'hF, lat, ack, err, rd);
        check("err_addr_err", err, 1'b1);
        check("err_addr_ack", ack, 1'b0);
        xact(1'b0, 1'b0, 32'h0, 64'h0, 8'hF, lat, ack, err, rd);
        check("err_addr_mem", rd, 64'h13579BDF);

        // partial write aborted by dropping cyc in RD
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h10, 64'hFFFFFFFF, 8'h1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            seen = seen | ack32 | err32;
        end
        check("abort_rd_noack", seen, 1'b0);
        xact(1'b0, 1'b0, 32'h10, 64'h0, 8'hF, lat, ack, err, rd);
        check("abort_rd_mem", rd, 64'hDEADBEEF);

        // request held across a clear sweep
        @(negedge clk);
        rst32 = 1'b1;
        @(negedge clk);
        rst32 = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 64'h0, 8'hF);
        n = 0;
        done_at = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (init32 && done_at == 0) done_at = n;
            seen = ack32 | err32;
        end
        check("init_hold_done", 64'(done_at), 64'd16);
        check("init_hold_lat", 64'(n), 64'd18);
        check("init_hold_err", err32, 1'b0);
        check("init_hold_data", rdat32, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);

        // 64-bit instance
        xact(1'b1, 1'b1, 32'h18, 64'h0123456789ABCDEF, 8'hFF, lat, ack, err, rd);
        check("w64_lat", 64'(lat), 64'd1);
        xact(1'b1, 1'b1, 32'h18, 64'hFFFFFFFFFFFFFFFF, 8'h81, lat, ack, err, rd);
        check("rmw64_lat", 64'(lat), 64'd3);
        xact(1'b1, 1'b0, 32'h18, 64'h0, 8'hFF, lat, ack, err, rd);
        check("rmw64_data", rd, 64'hFF23456789ABCDFF);

        // async reset while the merged write is pending
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h18, 64'h0, 8'h0F);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst64 = 1'b1;
        #1;
        check("rst_wr_ack", ack64, 1'b0);
        check("rst_wr_err", err64, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
        @(posedge clk);
        #1;
        check("rst_wr_ack_hold", ack64 | err64, 1'b0);
        @(negedge clk);
        rst64 = 1'b0;
        xact(1'b1, 1'b0, 32'h18, 64'h0, 8'hFF, lat, ack, err, rd);
        check("rst_wr_mem", rd, 64'hFF23456789ABCDFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
